// File: rtl/rtc_seq_engine.sv
// -----------------------------------------------------------------------------
// rtc_seq_engine
//
// Table-driven transaction sequencer for the RTC control path. One engine runs
// any of NSEQ sequences. Each step of a sequence is a single bus write or read
// taken from an external combinational table indexed by (sequence, step).
// Sequence 0 is the init sequence. It runs automatically after reset, and no
// other sequence may start until it has completed once.
//
// Ports
//   clock, reset        system clock; asynchronous active-high reset
//   start_req[NSEQ]     request strobes, one per sequence (pulse or level)
//   tbl_seq/tbl_step    table index driven by the engine
//   tbl_addr/tbl_data   table contents for the indexed step
//   tbl_rd/tbl_last     table flags: read step / final step of the sequence
//   bus_addr/bus_wdata  registered transfer address and write data
//   bus_wr/bus_rd       transfer strobes, held until bus_done
//   bus_done/bus_rdata  one-cycle completion pulse, read data valid with it
//   rd_valid/rd_data/rd_step  one-cycle pulse with captured read data + step
//   active_seq          sequence currently (or most recently) running
//   busy                engine not idle
//   seq_done/seq_err    one-cycle pulses: normal completion / timeout abort
//   init_done           sticky, set when sequence 0 completes
// -----------------------------------------------------------------------------
module rtc_seq_engine #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int NSEQ    = 4,
  parameter int SEQ_W   = 2,
  parameter int STEP_W  = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NSEQ-1:0]   start_req,
  output logic [SEQ_W-1:0]  tbl_seq,
  output logic [STEP_W-1:0] tbl_step,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              tbl_rd,
  input  logic              tbl_last,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [STEP_W-1:0] rd_step,
  output logic [SEQ_W-1:0]  active_seq,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic              init_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_XFER,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Step timer sized to hold TIMEOUT; a single bit when the timeout is off.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [NSEQ-1:0]  INIT_MASK = NSEQ'(1);

  state_e              state_q, state_d;
  logic [NSEQ-1:0]     pending_q, pending_d;
  logic                init_done_q, init_done_d;
  logic [SEQ_W-1:0]    active_seq_q, active_seq_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rd_flag_q, rd_flag_d;
  logic                last_flag_q, last_flag_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [STEP_W-1:0]   rd_step_q, rd_step_d;
  logic                seq_err_q, seq_err_d;

  logic [NSEQ-1:0]     eligible;
  logic                win_valid;
  logic [SEQ_W-1:0]    win_idx;
  logic [NSEQ-1:0]     pending_set;
  logic [NSEQ-1:0]     pending_clr;

  // ---------------------------------------------------------------------------
  // Arbitration: until init has completed only sequence 0 may start. Among the
  // eligible pending requests the lowest index wins; scanning downwards lets
  // the last (lowest) hit overwrite the others.
  // ---------------------------------------------------------------------------
  always_comb begin
    eligible  = init_done_q ? pending_q : (pending_q & INIT_MASK);
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NSEQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        win_valid = 1'b1;
        win_idx   = SEQ_W'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic.
  // NOTE: every signal assigned here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    init_done_d  = init_done_q;
    active_seq_d = active_seq_q;
    step_d       = step_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_flag_d    = rd_flag_q;
    last_flag_d  = last_flag_q;
    timer_d      = timer_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    rd_step_d    = rd_step_q;
    seq_err_d    = 1'b0;
    pending_set  = start_req;
    pending_clr  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          active_seq_d         = win_idx;
          step_d               = '0;
          pending_clr[win_idx] = 1'b1;
          state_d              = ST_FETCH;
        end
      end

      ST_FETCH: begin
        addr_d      = tbl_addr;
        wdata_d     = tbl_data;
        rd_flag_d   = tbl_rd;
        last_flag_d = tbl_last;
        timer_d     = '0;
        state_d     = ST_XFER;
      end

      ST_XFER: begin
        if (bus_done) begin
          if (rd_flag_q) begin
            rd_data_d  = bus_rdata;
            rd_step_d  = step_q;
            rd_valid_d = 1'b1;
          end
          state_d = ST_NEXT;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          // Abort. A failed init has to be retried, so re-arm its request.
          seq_err_d = 1'b1;
          state_d   = ST_IDLE;
          if (active_seq_q == '0) begin
            pending_set[0] = 1'b1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_NEXT: begin
        // The final table index also ends the sequence, so an unterminated
        // table cannot wrap back to step 0.
        if (last_flag_q || (step_q == '1)) begin
          state_d = ST_DONE;
        end else begin
          step_d  = step_q + STEP_W'(1);
          state_d = ST_FETCH;
        end
      end

      ST_DONE: begin
        if (active_seq_q == '0) begin
          init_done_d = 1'b1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A request arriving in the cycle its sequence is selected is kept, so
    // the sequence runs again afterwards.
    pending_d = (pending_q & ~pending_clr) | pending_set;
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed in the previous cycle regardless of order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= INIT_MASK;
      init_done_q  <= 1'b0;
      active_seq_q <= '0;
      step_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_flag_q    <= 1'b0;
      last_flag_q  <= 1'b0;
      timer_q      <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_step_q    <= '0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      init_done_q  <= init_done_d;
      active_seq_q <= active_seq_d;
      step_q       <= step_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_flag_q    <= rd_flag_d;
      last_flag_q  <= last_flag_d;
      timer_q      <= timer_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_step_q    <= rd_step_d;
      seq_err_q    <= seq_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The strobes are decoded straight from the state register, so they
  // can only be high in XFER, are mutually exclusive, and fall as soon as the
  // asynchronous reset clears the state.
  // ---------------------------------------------------------------------------
  assign bus_wr     = (state_q == ST_XFER) & ~rd_flag_q;
  assign bus_rd     = (state_q == ST_XFER) &  rd_flag_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign tbl_seq    = active_seq_q;
  assign tbl_step   = step_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_step    = rd_step_q;
  assign active_seq = active_seq_q;
  assign busy       = (state_q != ST_IDLE);
  assign seq_done   = (state_q == ST_DONE);
  assign seq_err    = seq_err_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_rtc_seq_engine.sv
// -----------------------------------------------------------------------------
// tb_rtc_seq_engine
//
// Scoreboard bench for rtc_seq_engine. Stimulus decides which sequences should
// run and in what order, then expands each one from the table into expected
// bus transfers and completion events. A bus agent answers the strobes and
// compares every transfer, while separate monitors compare read-data pulses
// and sequence completion/abort events.
// -----------------------------------------------------------------------------
module tb_rtc_seq_engine;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int NSEQ    = 4;
  localparam int SEQ_W   = 2;
  localparam int STEP_W  = 5;
  localparam int TIMEOUT = 8;
  localparam int NSTEP   = 1 << STEP_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NSEQ-1:0]   start_req = '0;
  logic [SEQ_W-1:0]  tbl_seq;
  logic [STEP_W-1:0] tbl_step;
  logic [ADDR_W-1:0] tbl_addr;
  logic [DATA_W-1:0] tbl_data;
  logic              tbl_rd;
  logic              tbl_last;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wr;
  logic              bus_rd;
  logic              bus_done = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [STEP_W-1:0] rd_step;
  logic [SEQ_W-1:0]  active_seq;
  logic              busy;
  logic              seq_done;
  logic              seq_err;
  logic              init_done;

  always #5 clock = ~clock;

  rtc_seq_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NSEQ   (NSEQ),
    .SEQ_W  (SEQ_W),
    .STEP_W (STEP_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start_req (start_req),
    .tbl_seq   (tbl_seq),
    .tbl_step  (tbl_step),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .tbl_rd    (tbl_rd),
    .tbl_last  (tbl_last),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_done  (bus_done),
    .bus_rdata (bus_rdata),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_step   (rd_step),
    .active_seq(active_seq),
    .busy      (busy),
    .seq_done  (seq_done),
    .seq_err   (seq_err),
    .init_done (init_done)
  );

  // ---------------------------------------------------------------------------
  // Sequence table
  // ---------------------------------------------------------------------------
  logic [7:0] t_addr [NSEQ][NSTEP];
  logic [7:0] t_data [NSEQ][NSTEP];
  logic       t_rd   [NSEQ][NSTEP];
  logic       t_last [NSEQ][NSTEP];

  assign tbl_addr = t_addr[tbl_seq][tbl_step];
  assign tbl_data = t_data[tbl_seq][tbl_step];
  assign tbl_rd   = t_rd[tbl_seq][tbl_step];
  assign tbl_last = t_last[tbl_seq][tbl_step];

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct {
    int         seq;
    int         step;
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
  } xfer_t;

  typedef struct {
    int   seq;
    logic err;
  } seqev_t;

  typedef struct {
    logic [7:0] data;
    int         step;
  } rdev_t;

  xfer_t  bus_q[$];
  seqev_t seq_q[$];
  rdev_t  rd_q[$];

  int checks = 0;
  int errors = 0;

  bit to_mode   = 1'b0;  // withhold bus_done on step 2 of sequence 3
  bit stray_req = 1'b0;  // fire one bus_done while the engine is idle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expand one sequence run from the table: walk until the last flag or the
  // final table index; cut >= 0 stops early at that step and expects an abort.
  task automatic expect_seq(input int s, input int cut = -1);
    for (int k = 0; k < NSTEP; k++) begin
      bus_q.push_back('{seq: s, step: k, addr: t_addr[s][k], data: t_data[s][k], rd: t_rd[s][k]});
      if (t_last[s][k] || (k == cut)) break;
    end
    seq_q.push_back('{seq: s, err: (cut >= 0)});
  endtask

  task automatic pulse_req(input logic [NSEQ-1:0] m);
    start_req = m;
    @(negedge clock);
    start_req = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (!busy && bus_q.size() == 0 && seq_q.size() == 0 && rd_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Bus agent: answers strobes after a chosen delay and checks each transfer.
  // ---------------------------------------------------------------------------
  initial begin : bus_agent
    bit    in_xfer  = 1'b0;
    bit    withhold = 1'b0;
    int    hi_cnt   = 0;
    int    delay    = 0;
    xfer_t cur;
    logic  [7:0] rdata;
    cur = '{seq: -1, step: 0, addr: 8'h00, data: 8'h00, rd: 1'b0};
    forever begin
      @(negedge clock);
      if (reset) begin
        in_xfer  = 1'b0;
        withhold = 1'b0;
        hi_cnt   = 0;
        bus_done = 1'b0;
        continue;
      end
      if (bus_done) bus_done = 1'b0;
      if ((bus_wr || bus_rd) && !in_xfer) begin
        in_xfer = 1'b1;
        hi_cnt  = 0;
        check("strobe_exclusive", bus_wr & bus_rd, 0);
        check("xfer_expected", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          cur = bus_q.pop_front();
          check("xfer_addr", bus_addr, cur.addr);
          check("xfer_rd", bus_rd, cur.rd);
          check("xfer_wr", bus_wr, !cur.rd);
          if (!cur.rd) check("xfer_wdata", bus_wdata, cur.data);
          check("xfer_seq", active_seq, cur.seq);
          check("xfer_step", tbl_step, cur.step);
          delay    = (cur.seq == 0) ? 2 : int'($urandom_range(0, 4));
          withhold = to_mode && (cur.seq == 3) && (cur.step == 2);
        end else begin
          delay    = 0;
          withhold = 1'b0;
          cur.rd   = 1'b0;
        end
      end
      if (bus_wr || bus_rd) begin
        hi_cnt++;
        if (!withhold && (hi_cnt - 1 == delay)) begin
          bus_done = 1'b1;
          rdata    = (cur.seq == 1) ? 8'(8'h30 + cur.step) : 8'($urandom);
          bus_rdata = rdata;
          if (cur.rd) rd_q.push_back('{data: rdata, step: cur.step});
        end
      end else if (in_xfer) begin
        in_xfer = 1'b0;
        if (withhold) check("timeout_strobe_cycles", hi_cnt, TIMEOUT);
        withhold = 1'b0;
      end else if (stray_req) begin
        bus_done  = 1'b1;
        bus_rdata = 8'hEE;
        stray_req = 1'b0;
      end
    end
  end

  // Read-data monitor
  initial begin : rd_monitor
    rdev_t e;
    forever begin
      @(negedge clock);
      if (!reset && rd_valid) begin
        check("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_step", rd_step, e.step);
        end
      end
    end
  end

  // Sequence completion / abort monitor
  initial begin : seq_monitor
    seqev_t e;
    forever begin
      @(negedge clock);
      if (!reset && (seq_done || seq_err)) begin
        check("seq_event_expected", seq_q.size() != 0, 1);
        if (seq_q.size() != 0) begin
          e = seq_q.pop_front();
          check("seq_event_seq", active_seq, e.seq);
          check("seq_err_flag", seq_err, e.err);
          check("seq_done_flag", seq_done, !e.err);
          if (e.err) check("busy_after_abort", busy, 0);
        end
      end
    end
  end

  // Watchdog: bounds the whole run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int  len3;
    bit  ok;
    bit  early_init;
    logic [NSEQ-1:0] m;

    // Table contents
    for (int s = 0; s < NSEQ; s++) begin
      for (int k = 0; k < NSTEP; k++) begin
        t_addr[s][k] = 8'($urandom);
        t_data[s][k] = 8'($urandom);
        t_rd[s][k]   = 1'($urandom);
        t_last[s][k] = 1'b0;
      end
    end
    for (int k = 0; k < 17; k++) begin
      t_addr[0][k] = 8'(8'h02 + k);
      t_data[0][k] = 8'(8'h10 + k);
      t_rd[0][k]   = 1'b0;
    end
    t_last[0][16] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      t_addr[1][k] = (k == 0) ? 8'hF0 : 8'(8'h26 + 3 * (k - 1));
      t_rd[1][k]   = 1'b1;
    end
    t_last[1][10] = 1'b1;
    len3 = int'($urandom_range(3, 8));
    t_last[3][len3 - 1] = 1'b1;
    // Sequence 2 has no last flag: it must stop at the final table index.

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_rd", bus_rd, 0);
    check("rst_init_done", init_done, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_active_seq", active_seq, 0);
    check("rst_bus_addr", bus_addr, 0);

    // Init runs by itself; a request for seq 2 during init waits for it.
    expect_seq(0);
    expect_seq(2);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("init_running", busy, 1);
    pulse_req(4'b0100);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (seq_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("init_seq_done_seen", ok, 1);
    check("init_done_low_in_done", init_done, 0);
    @(negedge clock);
    check("gate_idle_after_init", busy, 0);
    check("init_done_set", init_done, 1);
    @(negedge clock);
    check("gate_seq2_busy", busy, 1);
    check("gate_seq2_active", active_seq, 2);
    wait_idle("idle_after_seq2", 600);

    // Arbitration with a re-latched request: 1, then 1 again, then 3.
    expect_seq(1);
    expect_seq(1);
    expect_seq(3);
    pulse_req(4'b1010);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus_rd && active_seq == 1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("seq1_started", ok, 1);
    pulse_req(4'b0010);
    wait_idle("idle_after_arb", 600);

    // bus_done while idle has no effect.
    stray_req = 1'b1;
    repeat (4) @(negedge clock);
    check("stray_done_ignored", busy, 0);

    // Random request masks, issued while idle.
    for (int i = 0; i < 6; i++) begin
      m = NSEQ'($urandom_range(1, 15));
      for (int k = 0; k < NSEQ; k++) begin
        if (m[k]) expect_seq(k);
      end
      pulse_req(m);
      wait_idle("idle_after_random", 1200);
    end

    // Timeout on step 2 of sequence 3.
    to_mode = 1'b1;
    expect_seq(3, 2);
    pulse_req(4'b1000);
    wait_idle("idle_after_timeout", 200);
    to_mode = 1'b0;

    // Reset in the middle of a read transfer.
    expect_seq(1);
    pulse_req(4'b0010);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus_rd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("midop_xfer_seen", ok, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midop_bus_rd_async", bus_rd, 0);
    check("midop_busy_async", busy, 0);
    bus_q.delete();
    rd_q.delete();
    seq_q.delete();
    repeat (2) @(negedge clock);
    check("midop_init_done_cleared", init_done, 0);
    expect_seq(0);
    reset = 1'b0;
    early_init = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (init_done) early_init = 1'b1;
      if (seq_done) begin
        ok = 1'b1;
        break;
      end
    end
    check("rerun_seq_done_seen", ok, 1);
    check("rerun_init_done_early", early_init, 0);
    @(negedge clock);
    check("rerun_init_done_set", init_done, 1);
    wait_idle("idle_final", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
